// File: rtl/seq_stage_ctrl_if.sv
// Handshake and datapath-facing bundle for the Y86-64 SEQ stage sequencer.
// The master side is the sequencer; the slave side is the core/stage blocks.
interface seq_stage_ctrl_if;
  logic        start;
  logic [3:0]  icode;
  logic        cond;
  logic [63:0] valC;
  logic [63:0] valM;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic        mem_ack;
  logic        dmem_error;

  logic [63:0] pc;
  logic        fetch_en;
  logic        decode_en;
  logic        exec_en;
  logic        wb_en;
  logic        mem_req;
  logic [1:0]  stat;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    input  start, icode, cond, valC, valM, valP,
           instr_valid, imem_error, mem_ack, dmem_error,
    output pc, fetch_en, decode_en, exec_en, wb_en, mem_req,
           stat, halted, instr_count
  );

  modport slave (
    output start, icode, cond, valC, valM, valP,
           instr_valid, imem_error, mem_ack, dmem_error,
    input  pc, fetch_en, decode_en, exec_en, wb_en, mem_req,
           stat, halted, instr_count
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ sequencer: steps one instruction through six stages, owns the
// architectural PC, runs the data-memory handshake with timeout, latches status.
module seq_stage_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  seq_stage_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00, STAT_HLT = 2'b01, STAT_ADR = 2'b10, STAT_INS = 2'b11
  } stat_t;

  state_t      state, state_nxt;
  stat_t       stat_q, stat_nxt;
  logic [63:0] pc_q, next_pc;
  logic [31:0] count_q;
  logic [7:0]  wait_q;
  logic        is_mem;
  logic        timeout;

  assign is_mem  = bus.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  // An ack in the timeout cycle is checked first, so it still completes normally.
  assign timeout = (wait_q == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    state_nxt = state;
    stat_nxt  = stat_q;
    case (state)
      S_IDLE:      if (bus.start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_error) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_HALTED;
        end else if (!bus.instr_valid) begin
          stat_nxt  = STAT_INS;
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.icode == 4'h0) begin
          stat_nxt  = STAT_HLT;
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE:   state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!is_mem) begin
          state_nxt = S_WRITEBACK;
        end else if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = S_HALTED;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (timeout) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_HALTED;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = S_FETCH;
      S_HALTED:    state_nxt = S_HALTED;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    next_pc = bus.valP;
    case (bus.icode)
      4'h7:    next_pc = bus.cond ? bus.valC : bus.valP;
      4'h8:    next_pc = bus.valC;
      4'h9:    next_pc = bus.valM;
      default: next_pc = bus.valP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      stat_q  <= STAT_AOK;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state  <= state_nxt;
      stat_q <= stat_nxt;
      if (state == S_PCUPD) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
      end
      wait_q <= (state == S_MEMORY && !bus.mem_ack) ? wait_q + 8'd1 : 8'd0;
    end
  end

  // Strobes are pure state decodes, so reset clears them asynchronously.
  assign bus.fetch_en    = (state == S_FETCH);
  assign bus.decode_en   = (state == S_DECODE);
  assign bus.exec_en     = (state == S_EXECUTE);
  assign bus.wb_en       = (state == S_WRITEBACK);
  assign bus.mem_req     = (state == S_MEMORY) && is_mem;
  assign bus.halted      = (state == S_HALTED);
  assign bus.pc          = pc_q;
  assign bus.stat        = stat_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus a random
// instruction stream, checked cycle by cycle against a stage-list model.
module tb_seq_stage_ctrl;

  localparam logic [63:0] RST_PC = 64'h80;
  localparam int          TMO    = 4;

  // Per-cycle observation vector {fetch_en, decode_en, exec_en, mem_req, wb_en, halted}
  localparam logic [5:0] ST_F = 6'b100000;
  localparam logic [5:0] ST_D = 6'b010000;
  localparam logic [5:0] ST_E = 6'b001000;
  localparam logic [5:0] ST_M = 6'b000100;
  localparam logic [5:0] ST_W = 6'b000010;
  localparam logic [5:0] ST_N = 6'b000000;
  localparam logic [5:0] ST_H = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [63:0] m_pc;
  logic [31:0] m_count;

  seq_stage_ctrl_if bus ();

  seq_stage_ctrl #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] strobes();
    return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req, bus.wb_en, bus.halted};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    total_cnt++;
    if (strobes() !== ST_N || bus.pc !== RST_PC || bus.stat !== 2'b00 || bus.instr_count !== 32'd0) begin
      $display("FAIL reset_state: strobes=%b pc=%h stat=%b count=%0d, want strobes=%b pc=%h stat=00 count=0",
               strobes(), bus.pc, bus.stat, bus.instr_count, ST_N, RST_PC);
    end else pass_cnt++;
    @(negedge clk);
    rst     = 1'b0;
    m_pc    = RST_PC;
    m_count = 32'd0;
  endtask

  // Leaves the bench at the negedge inside the first FETCH cycle.
  task automatic start_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; ack_at is the MEMORY cycle carrying the ack (0 = never).
  task automatic run_instr(input string name, input logic [3:0] ic, input logic c,
                           input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                           input int ack_at, input logic derr, input logic ivalid, input logic ierr);
    logic [5:0]  exp_q[$];
    logic [1:0]  exp_stat = 2'b00;
    logic [63:0] exp_pc   = m_pc;
    bit          halts    = 1'b1;
    int          mem_cyc  = 0;
    logic [5:0]  got;

    bus.icode = ic;  bus.cond = c;  bus.valC = vc;  bus.valM = vm;  bus.valP = vp;
    bus.instr_valid = ivalid;  bus.imem_error = ierr;

    exp_q.push_back(ST_F);
    if (ierr)        exp_stat = 2'b10;
    else if (!ivalid) exp_stat = 2'b11;
    else begin
      exp_q.push_back(ST_D);
      if (ic == 4'h0) exp_stat = 2'b01;
      else begin
        exp_q.push_back(ST_E);
        if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
          int k;
          k = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;
          repeat (k) exp_q.push_back(ST_M);
          if (k != ack_at || derr) exp_stat = 2'b10;
        end else begin
          exp_q.push_back(ST_N);
        end
        if (exp_stat == 2'b00) begin
          exp_q.push_back(ST_W);
          exp_q.push_back(ST_N);
          halts = 1'b0;
          case (ic)
            4'h7:    exp_pc = c ? vc : vp;
            4'h8:    exp_pc = vc;
            4'h9:    exp_pc = vm;
            default: exp_pc = vp;
          endcase
        end
      end
    end

    foreach (exp_q[i]) begin
      bus.start = 1'($urandom);
      if (exp_q[i] == ST_M) begin
        mem_cyc++;
        bus.mem_ack    = (mem_cyc == ack_at);
        bus.dmem_error = derr;
      end else begin
        bus.mem_ack    = 1'($urandom);
        bus.dmem_error = 1'($urandom);
      end
      #1;
      got = strobes();
      total_cnt++;
      if (got !== exp_q[i])
        $display("FAIL %s strobes cycle %0d: got %b want %b", name, i, got, exp_q[i]);
      else pass_cnt++;
      @(negedge clk);
    end

    bus.mem_ack = 1'b0;
    bus.start   = 1'b0;
    #1;
    total_cnt++;
    if (halts) begin
      if (strobes() !== ST_H || bus.stat !== exp_stat || bus.pc !== m_pc || bus.instr_count !== m_count)
        $display("FAIL %s halt: strobes=%b stat=%b pc=%h count=%0d, want strobes=%b stat=%b pc=%h count=%0d",
                 name, strobes(), bus.stat, bus.pc, bus.instr_count, ST_H, exp_stat, m_pc, m_count);
      else pass_cnt++;
    end else begin
      if (strobes() !== ST_F || bus.stat !== 2'b00 || bus.pc !== exp_pc || bus.instr_count !== m_count + 32'd1)
        $display("FAIL %s retire: strobes=%b stat=%b pc=%h count=%0d, want strobes=%b stat=00 pc=%h count=%0d",
                 name, strobes(), bus.stat, bus.pc, bus.instr_count, ST_F, exp_pc, m_count + 32'd1);
      else pass_cnt++;
      m_pc    = exp_pc;
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) begin
      #1;
      total_cnt++;
      if (strobes() !== ST_N) $display("FAIL idle_hold: strobes=%b want %b", strobes(), ST_N);
      else pass_cnt++;
      @(negedge clk);
    end
    start_run();
  endtask

  task automatic test_opq();
    run_instr("opq", 4'h6, 1'b0, 64'h0, 64'h0, 64'h2, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_jxx();
    run_instr("jxx_taken",     4'h7, 1'b1, 64'h100, 64'h0, 64'h9, 0, 1'b0, 1'b1, 1'b0);
    run_instr("jxx_not_taken", 4'h7, 1'b0, 64'h100, 64'h0, 64'h9, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_call_delayed();
    run_instr("call_ack3", 4'h8, 1'b0, 64'h40, 64'h0, 64'h55, 3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ret();
    run_instr("ret_ack1", 4'h9, 1'b0, 64'h0, 64'h1234, 64'h77, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ack_at_timeout();
    run_instr("push_ack_at_limit", 4'hA, 1'b0, 64'h0, 64'h0, 64'h3C, TMO, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr("random", 4'($urandom_range(1, 15)), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(1, TMO), 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    run_instr("opq_pre", 4'h6, 1'b0, 64'h0, 64'h0, 64'h2, 0, 1'b0, 1'b1, 1'b0);
    run_instr("mrmov_timeout", 4'h5, 1'b0, 64'h0, 64'h0, 64'hA, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      bus.start   = 1'b1;
      bus.mem_ack = 1'b1;
      @(negedge clk);
      #1;
      total_cnt++;
      if (strobes() !== ST_H || bus.pc !== m_pc || bus.instr_count !== m_count || bus.stat !== 2'b10)
        $display("FAIL halted_frozen: strobes=%b pc=%h count=%0d stat=%b, want strobes=%b pc=%h count=%0d stat=10",
                 strobes(), bus.pc, bus.instr_count, bus.stat, ST_H, m_pc, m_count);
      else pass_cnt++;
    end
    bus.start   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_dmem_error();
    do_reset();
    start_run();
    run_instr("rmmov_dmem_err", 4'h4, 1'b0, 64'h0, 64'h0, 64'hA, 2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_halt_instr();
    do_reset();
    start_run();
    run_instr("ret_then_halt", 4'h9, 1'b0, 64'h0, 64'h300, 64'h0, 2, 1'b0, 1'b1, 1'b0);
    run_instr("halt", 4'h0, 1'b0, 64'h0, 64'h0, 64'h99, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_invalid_instr();
    do_reset();
    start_run();
    run_instr("invalid", 4'h6, 1'b0, 64'h0, 64'h0, 64'h5, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_imem_error();
    do_reset();
    start_run();
    run_instr("imem_err", 4'h6, 1'b0, 64'h0, 64'h0, 64'h5, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_rst_mid_mem();
    do_reset();
    start_run();
    run_instr("opq_before_rst", 4'h6, 1'b0, 64'h0, 64'h0, 64'h222, 0, 1'b0, 1'b1, 1'b0);
    bus.icode = 4'h5;
    bus.mem_ack = 1'b0;
    repeat (4) @(negedge clk);  // FETCH -> DECODE -> EXECUTE -> MEMORY 1 -> MEMORY 2
    #1;
    total_cnt++;
    if (bus.mem_req !== 1'b1) $display("FAIL mem_wait_req: mem_req=%b want 1", bus.mem_req);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (strobes() !== ST_N || bus.pc !== RST_PC || bus.instr_count !== 32'd0 || bus.stat !== 2'b00)
      $display("FAIL async_reset: strobes=%b pc=%h count=%0d stat=%b, want strobes=%b pc=%h count=0 stat=00",
               strobes(), bus.pc, bus.instr_count, bus.stat, ST_N, RST_PC);
    else pass_cnt++;
    @(negedge clk);
    rst     = 1'b0;
    m_pc    = RST_PC;
    m_count = 32'd0;
    start_run();
    run_instr("opq_after_rst", 4'h6, 1'b0, 64'h0, 64'h0, 64'h2, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.icode = 4'h1;  bus.cond = 1'b0;
    bus.valC = '0;  bus.valM = '0;  bus.valP = '0;
    bus.instr_valid = 1'b1;  bus.imem_error = 1'b0;
    bus.mem_ack = 1'b0;  bus.dmem_error = 1'b0;
    m_pc = RST_PC;
    m_count = 32'd0;

    test_reset();
    test_opq();
    test_jxx();
    test_call_delayed();
    test_ret();
    test_ack_at_timeout();
    test_random();
    test_timeout();
    test_dmem_error();
    test_halt_instr();
    test_invalid_instr();
    test_imem_error();
    test_rst_mid_mem();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
